// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants: load/swap opcode encodings and hazard-unit state encoding.
// No logic; pure declarations imported by the pipeline control blocks.
// No flow control of its own.
package hazard_stall_unit_pkg;

    // Opcodes that read memory and therefore cannot forward their result
    // in time for an instruction sitting directly behind them in ID.
    localparam logic [3:0] LOAD_OP_A_DEF = 4'b0100;
    localparam logic [3:0] LOAD_OP_B_DEF = 4'b0110;

    // Register swap is an R-type style instruction selected by opcode plus function code.
    localparam logic [3:0] SWAP_OP       = 4'b1111;
    localparam logic [3:0] SWAP_FUNC     = 4'b0010;

    // RUN: normal issue, STALL1: second bubble for a branch behind a load,
    // HALT: pipeline frozen while a halt is requested.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL1 = 2'd1,
        ST_HALT   = 2'd2
    } hsu_state_e;

endpackage

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: freezes PC and IF/ID, bubbles ID/EX, flushes IF/ID on taken branches.
// Stall decisions are combinational in the same cycle; STALL1/HALT add registered follow-on stalls.
// While stalled, BranchTaken is ignored so the branch is re-evaluated once operands are ready.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter logic [3:0] LOAD_OP_A = LOAD_OP_A_DEF,
    parameter logic [3:0] LOAD_OP_B = LOAD_OP_B_DEF,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       HazardDetected,
    input  logic [3:0]       OpcodeEX,
    input  logic [3:0]       DestEX,
    input  logic [3:0]       IDOP1,
    input  logic [3:0]       IDOP2,
    input  logic             UsesOP2ID,
    input  logic             BranchID,
    input  logic             BranchTaken,
    input  logic             HaltReq,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [CNT_W-1:0] StallCount
);

    hsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              load_use;
    logic              run_stall;
    hsu_state_e        run_next;
    logic              stall;
    logic              ifid_flush;

    // Only the EX/MEM branch-forwarding flag matters here; bit 0 is consumed elsewhere.
    logic              unused_hd0;
    assign unused_hd0 = HazardDetected[0];

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = ((OpcodeEX == LOAD_OP_A) || (OpcodeEX == LOAD_OP_B)) &&
                   ((DestEX == IDOP1) || (UsesOP2ID && (DestEX == IDOP2)));
    end

    // Issue rules used in RUN and on the cycle a halt is released.
    always_comb begin
        run_stall = load_use || (BranchID && HazardDetected[1]) || HaltReq;
        if (HaltReq) begin
            run_next = ST_HALT;
        end else if (BranchID && load_use) begin
            run_next = ST_STALL1;
        end else begin
            run_next = ST_RUN;
        end
    end

    // Next-state and stall/flush decision per state.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall      = run_stall;
                ifid_flush = !run_stall && BranchTaken && BranchID;
                state_d    = run_next;
            end
            ST_STALL1: begin
                stall   = 1'b1;
                state_d = HaltReq ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (HaltReq) begin
                    stall   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    // Release cycle behaves exactly like RUN.
                    stall      = run_stall;
                    ifid_flush = !run_stall && BranchTaken && BranchID;
                    state_d    = run_next;
                end
            end
            default: begin
                stall   = 1'b1;
                state_d = ST_RUN;
            end
        endcase
    end

    // Output drive; reset holds the front end frozen and flushed.
    always_comb begin
        if (reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else begin
            PCWrite   = !stall;
            IFIDWrite = !stall;
            IFIDFlush = ifid_flush;
            IDEXFlush = stall;
        end
    end

    // Saturating count of bubble cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State register; reset abandons any pending STALL1/HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign StallCount = cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter LOAD_OP_A, default 4'b0100: first load opcode.
REQ-002 SHALL have parameter LOAD_OP_B, default 4'b0110: second load opcode.
REQ-003 SHALL have parameter CNT_W, default 8: width of the stall counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports clk and reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port HazardDetected, input, 2 bits: forwarding-unit hazard flags; bit1 means branch operand is forwarded from the EX/MEM path.
REQ-008 SHALL have port OpcodeEX, input, 4 bits: opcode in EX.
REQ-009 SHALL have port DestEX, input, 4 bits: destination register in EX.
REQ-010 SHALL have port IDOP1, input, 4 bits: ID source register 1.
REQ-011 SHALL have port IDOP2, input, 4 bits: ID source register 2.
REQ-012 SHALL have port UsesOP2ID, input, 1 bit: ID instruction reads IDOP2.
REQ-013 SHALL have port BranchID, input, 1 bit: branch in ID.
REQ-014 SHALL have port BranchTaken, input, 1 bit: branch resolved taken in ID.
REQ-015 SHALL have port HaltReq, input, 1 bit: halt request (level).
REQ-016 SHALL have port PCWrite, output, 1 bit: PC write enable.
REQ-017 SHALL have port IFIDWrite, output, 1 bit: IF/ID register write enable.
REQ-018 SHALL have port IFIDFlush, output, 1 bit: zero the IF/ID register.
REQ-019 SHALL have port IDEXFlush, output, 1 bit: insert a bubble into ID/EX.
REQ-020 SHALL have port StallCount, output, CNT_W bits: saturating count of stall cycles.

Function
REQ-021 SHALL define LoadUse = (OpcodeEX==LOAD_OP_A or OpcodeEX==LOAD_OP_B) and (DestEX==IDOP1 or (UsesOP2ID and DestEX==IDOP2)).
REQ-022 SHALL implement the FSM states RUN, STALL1 and HALT.
REQ-023 SHALL resolve RUN transitions in this priority: HaltReq -> HALT; BranchID and LoadUse -> STALL1; otherwise remain in RUN.
REQ-024 SHALL, in RUN, stall combinationally in the same cycle whenever any of the following holds: LoadUse; BranchID with HazardDetected[1]; HaltReq.
REQ-025 SHALL, for a stall in RUN, drive PCWrite=0, IFIDWrite=0 and IDEXFlush=1.
REQ-026 SHALL, in RUN with no stall, drive PCWrite=1, IFIDWrite=1 and IDEXFlush=0.
REQ-027 SHALL, in RUN with no stall, drive IFIDFlush=BranchTaken&BranchID.
REQ-028 SHALL ignore BranchTaken while stalled, because the branch is re-evaluated after the stall.
REQ-029 SHALL, in STALL1, stall unconditionally, giving 2 bubbles in total for a branch depending on a load, then go to RUN.
REQ-030 SHALL, in STALL1 with HaltReq asserted, go to HALT instead of RUN.
REQ-031 SHALL, in HALT, drive PCWrite=0, IFIDWrite=0, IDEXFlush=1 and IFIDFlush=0.
REQ-032 SHALL remain in HALT while HaltReq=1 and go to RUN on the first cycle with HaltReq=0; the outputs in that cycle follow RUN rules.
REQ-033 SHALL increment StallCount once for every clock edge taken while IDEXFlush=1, saturating at 2^CNT_W-1 with no wrap.
REQ-034 SHALL let a simultaneous LoadUse and BranchTaken produce only the stall, with IFIDFlush=0.

Reset
REQ-035 SHALL, while reset=1, immediately force the state to RUN and StallCount to 0.
REQ-036 SHALL, while reset=1, drive PCWrite=0, IFIDWrite=0, IFIDFlush=1 and IDEXFlush=1.
REQ-037 SHALL, on reset asserted mid-STALL1 or mid-HALT, abandon the pending stall; after release the FSM starts in RUN.

Structure
REQ-038 SHALL place the opcode constants (LOAD_OP_A/B, SWAP opcode and function code) and the state encoding enum in the shared pipeline package.
REQ-039 SHALL contain no sub-modules, with the FSM and counter inline.

Verification
REQ-040 SHALL verify: OpcodeEX=0110, DestEX=3, IDOP1=3 in RUN -> PCWrite=0, IDEXFlush=1 for exactly 1 cycle, StallCount 0->1.
REQ-041 SHALL verify: BranchID=1, OpcodeEX=0100, DestEX=5, IDOP1=5 -> 2 consecutive stall cycles (RUN then STALL1), StallCount=2.
REQ-042 SHALL verify: BranchID=1, HazardDetected=2'b10, OpcodeEX=0001 -> 1 stall cycle; the next cycle with BranchTaken=1 gives IFIDFlush=1.
REQ-043 SHALL verify: HaltReq held for 4 cycles -> PCWrite=0 for 4 cycles, StallCount=4; release gives PCWrite=1 the next cycle.
REQ-044 SHALL verify: 300 forced stalls with CNT_W=8 -> StallCount saturates at 255; reset asserted mid-STALL1 -> state RUN and StallCount=0 asynchronously.
